wm_ui_core: RTL and testbench
=============================

// Module: wm_ui_core
// PURPOSE
//   Washing-machine UI/timing core: clock-enable divider, wash-mode selector and
//   multiplexed 7-segment display driver in one block. Sits beside the time/water
//   controllers; supplies them the 1 Hz tick and the selected mode, and renders
//   remaining time, total time and water level on the board's 8-digit display.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency
//   TICK_HZ  1            programme tick rate (tick_1hz)
//   SCAN_HZ  10_000       display digit-scan rate (scan_tick)
// PORTS
//   clk            in   1  system clock, 100 MHz; the only clock
//   reset          in   1  asynchronous, active-high; clears all state
//   power_on       in   1  machine powered (power light)
//   run_state      in   2  00 idle, 01 running, 10 paused, 11 done
//   finish         in   1  programme complete
//   model_choose   in   1  mode-select button, level, synchronous to clk
//   current_time   in   7  remaining seconds, 0..127
//   total_time     in   7  total programme seconds, 0..127
//   current_water  in   3  water level 0..7
//   tick_1hz       out  1  one-cycle pulse at TICK_HZ
//   scan_tick      out  1  one-cycle pulse at SCAN_HZ
//   current_model  out  3  mode mask {wash,rinse,dry}
//   digit_show     out  8  segments {dp,g,f,e,d,c,b,a}, active low
//   AN             out  8  digit enables, active low, AN[0] = rightmost
// BEHAVIOUR
//   Reset: counters 0, tick_1hz=0, scan_tick=0, current_model=3'b111,
//     scan index 0, digit_show=8'hFF, AN=8'hFF.
//   Divider: free-running, independent of power_on. tick_1hz high for one cycle
//     when tick counter reaches CLK_HZ/TICK_HZ-1, then counter wraps to 0; first
//     pulse on cycle CLK_HZ/TICK_HZ after reset release. scan_tick identical with
//     CLK_HZ/SCAN_HZ. Integer division; ratios below 2 are unsupported.
//   Mode select: rising edge of model_choose detected with a 1-cycle prev register.
//     Edge advances mode only if power_on=1, finish=0 and run_state!=01.
//     Sequence 111->100->110->010->011->001->111 (wraps). Any other value (not
//     reachable) returns to 111. power_on=0 forces 111 next cycle, edges ignored.
//     Button held high gives exactly one advance.
//   Display: on power_on=0 AN=8'hFF, digit_show=8'hFF (registered, 1 cycle).
//     Otherwise on each scan_tick the scan index steps 0->1->2->3->4->0 and AN,
//     digit_show update on that same edge (registered; stable between ticks).
//     Index 0: current_time ones, 1: current_time tens, 2: total_time ones,
//     3: total_time tens, 4: current_water. Times >99 saturate to 99 before
//     split. Exactly one AN bit low (AN[index]); AN[7:5] always high. dp off.
//     Decimal digit codes (hex, active low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99,
//     5 92, 6 82, 7 F8, 8 80, 9 90. Leading zeros are shown (no blanking).
//   Inputs sampled when the digit is loaded; mid-scan input change appears on
//     the next visit of that digit. Reset mid-operation returns to reset values.
// STRUCTURE
//   Package wm_ui_pkg: SEG_LUT[0:9] constants, mode mask constants
//     (MODE_FULL=3'b111 etc.), run_state encodings.
//   One sub-module: wm_tick_gen (parameterised counter -> one-cycle pulse),
//     instantiated twice (TICK_HZ and SCAN_HZ). Mode FSM and scan mux inline.
// TESTING (CLK_HZ=100, TICK_HZ=1, SCAN_HZ=10)
//   Release reset -> tick_1hz pulses at cycles 100,200; scan_tick every 10 cycles,
//     each pulse exactly 1 cycle wide.
//   power_on=1, run_state=00, 3 model_choose pulses -> current_model 100,110,010;
//     7th pulse total wraps to 100; held-high button advances once.
//   run_state=01 or finish=1, pulse model_choose -> mode unchanged; drop
//     power_on -> 111.
//   current_time=45, total_time=120, water=3 -> scan sequence AN/digit
//     FE/92, FD/99, FB/90, F7/90, EF/B0, then repeats.
//   power_on=0 -> AN=FF, digit_show=FF; assert reset mid-scan -> all reset values
//     immediately (asynchronous), scan restarts at index 0.

Source files
------------

// File: rtl/wm_ui_pkg.sv
// Shared constants for the washing-machine UI core: segment codes,
// wash-mode masks, run-state encodings and small helper functions.
package wm_ui_pkg;

   // Seven-segment codes {dp,g,f,e,d,c,b,a}, active low, for digits 0..9
   localparam logic [7:0] SEG_LUT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Wash-mode masks {wash,rinse,dry}
   localparam logic [2:0] MODE_FULL       = 3'b111;
   localparam logic [2:0] MODE_WASH       = 3'b100;
   localparam logic [2:0] MODE_WASH_RINSE = 3'b110;
   localparam logic [2:0] MODE_RINSE      = 3'b010;
   localparam logic [2:0] MODE_RINSE_DRY  = 3'b011;
   localparam logic [2:0] MODE_DRY        = 3'b001;

   // Programme run-state encodings
   localparam logic [1:0] RUN_IDLE    = 2'b00;
   localparam logic [1:0] RUN_RUNNING = 2'b01;
   localparam logic [1:0] RUN_PAUSED  = 2'b10;
   localparam logic [1:0] RUN_DONE    = 2'b11;

   // Next mode in the button cycle; unreachable codes recover to full cycle
   function automatic logic [2:0] mode_step(input logic [2:0] mode);
      logic [2:0] nxt;
      case (mode)
         MODE_FULL:       nxt = MODE_WASH;
         MODE_WASH:       nxt = MODE_WASH_RINSE;
         MODE_WASH_RINSE: nxt = MODE_RINSE;
         MODE_RINSE:      nxt = MODE_RINSE_DRY;
         MODE_RINSE_DRY:  nxt = MODE_DRY;
         MODE_DRY:        nxt = MODE_FULL;
         default:         nxt = MODE_FULL;
      endcase
      return nxt;
   endfunction

   // Decimal digit to segment code; anything outside 0..9 is blanked
   function automatic logic [7:0] seg_encode(input logic [3:0] digit);
      logic [7:0] seg;
      if (digit < 4'd10) begin
         seg = SEG_LUT[digit];
      end else begin
         seg = SEG_BLANK;
      end
      return seg;
   endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Free-running clock-enable generator: one-cycle pulse every CLK_HZ/OUT_HZ
// cycles, first pulse on cycle CLK_HZ/OUT_HZ after reset release.
module wm_tick_gen #(
   parameter int CLK_HZ = 100_000_000,
   parameter int OUT_HZ = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int DIV = CLK_HZ / OUT_HZ;
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_r;

   // Count up to DIV-1, then wrap and emit a single-cycle registered pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
         tick    <= 1'b0;
      end else if (count_r == LAST) begin
         count_r <= '0;
         tick    <= 1'b1;
      end else begin
         count_r <= count_r + CW'(1);
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/wm_ui_core.sv
// Washing-machine UI/timing core: 1 Hz and display-scan clock enables,
// wash-mode selector and multiplexed 8-digit 7-segment display driver.
module wm_ui_core
   import wm_ui_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1,
   parameter int SCAN_HZ = 10_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_on,
   input  logic [1:0] run_state,
   input  logic       finish,
   input  logic       model_choose,
   input  logic [6:0] current_time,
   input  logic [6:0] total_time,
   input  logic [2:0] current_water,
   output logic       tick_1hz,
   output logic       scan_tick,
   output logic [2:0] current_model,
   output logic [7:0] digit_show,
   output logic [7:0] AN
);

   // ---------------------------------------------------------------
   // Clock enables
   // ---------------------------------------------------------------
   wm_tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(TICK_HZ)) u_tick_1hz (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_1hz)
   );

   wm_tick_gen #(.CLK_HZ(CLK_HZ), .OUT_HZ(SCAN_HZ)) u_tick_scan (
      .clk   (clk),
      .reset (reset),
      .tick  (scan_tick)
   );

   // ---------------------------------------------------------------
   // Mode selector
   // ---------------------------------------------------------------
   logic       choose_prev_r;
   logic       advance_s;
   logic [2:0] mode_r;
   logic [2:0] mode_next_s;

   // Remember the button level so only its rising edge is acted on
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         choose_prev_r <= 1'b0;
      end else begin
         choose_prev_r <= model_choose;
      end
   end

   // Mode state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r <= MODE_FULL;
      end else begin
         mode_r <= mode_next_s;
      end
   end

   // Next mode: power-off forces full cycle; edges honoured only when idle-ish
   always_comb begin
      advance_s   = model_choose & ~choose_prev_r & ~finish &
                    (run_state != RUN_RUNNING);
      mode_next_s = mode_r;
      if (!power_on) begin
         mode_next_s = MODE_FULL;
      end else if (advance_s) begin
         mode_next_s = mode_step(mode_r);
      end else begin
         mode_next_s = mode_r;
      end
   end

   // Mode output straight from the state register
   always_comb begin
      current_model = mode_r;
   end

   // ---------------------------------------------------------------
   // Display scan
   // ---------------------------------------------------------------
   logic [2:0] scan_idx_r;
   logic [2:0] scan_idx_next_s;
   logic [6:0] ct_sat_s;
   logic [6:0] tt_sat_s;
   logic [6:0] ct_ones_s;
   logic [6:0] ct_tens_s;
   logic [6:0] tt_ones_s;
   logic [6:0] tt_tens_s;
   logic [3:0] digit_s;
   logic [7:0] an_next_s;
   logic [7:0] seg_next_s;

   // Saturate times to two digits and split into tens/ones
   always_comb begin
      ct_sat_s  = (current_time > 7'd99) ? 7'd99 : current_time;
      tt_sat_s  = (total_time   > 7'd99) ? 7'd99 : total_time;
      ct_ones_s = ct_sat_s % 7'd10;
      ct_tens_s = ct_sat_s / 7'd10;
      tt_ones_s = tt_sat_s % 7'd10;
      tt_tens_s = tt_sat_s / 7'd10;
   end

   // Select the digit for the current scan position and the following position
   always_comb begin
      digit_s         = 4'd0;
      an_next_s       = AN_OFF;
      scan_idx_next_s = 3'd0;
      case (scan_idx_r)
         3'd0: begin
            digit_s         = ct_ones_s[3:0];
            an_next_s       = 8'hFE;
            scan_idx_next_s = 3'd1;
         end
         3'd1: begin
            digit_s         = ct_tens_s[3:0];
            an_next_s       = 8'hFD;
            scan_idx_next_s = 3'd2;
         end
         3'd2: begin
            digit_s         = tt_ones_s[3:0];
            an_next_s       = 8'hFB;
            scan_idx_next_s = 3'd3;
         end
         3'd3: begin
            digit_s         = tt_tens_s[3:0];
            an_next_s       = 8'hF7;
            scan_idx_next_s = 3'd4;
         end
         3'd4: begin
            digit_s         = {1'b0, current_water};
            an_next_s       = 8'hEF;
            scan_idx_next_s = 3'd0;
         end
         default: begin
            digit_s         = 4'd0;
            an_next_s       = AN_OFF;
            scan_idx_next_s = 3'd0;
         end
      endcase
      seg_next_s = seg_encode(digit_s);
   end

   // Load one digit per scan tick; blank everything while powered down
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_idx_r <= 3'd0;
         AN         <= AN_OFF;
         digit_show <= SEG_BLANK;
      end else if (!power_on) begin
         AN         <= AN_OFF;
         digit_show <= SEG_BLANK;
      end else if (scan_tick) begin
         scan_idx_r <= scan_idx_next_s;
         AN         <= an_next_s;
         digit_show <= seg_next_s;
      end
   end

endmodule

// File: tb/tb_wm_ui_core.sv
// Directed self-checking bench for wm_ui_core with scaled-down rates
// (CLK_HZ=100, TICK_HZ=1, SCAN_HZ=10).
module tb_wm_ui_core;

   logic       clk;
   logic       reset;
   logic       power_on;
   logic [1:0] run_state;
   logic       finish;
   logic       model_choose;
   logic [6:0] current_time;
   logic [6:0] total_time;
   logic [2:0] current_water;
   logic       tick_1hz;
   logic       scan_tick;
   logic [2:0] current_model;
   logic [7:0] digit_show;
   logic [7:0] AN;

   int checks;
   int errors;

   wm_ui_core #(.CLK_HZ(100), .TICK_HZ(1), .SCAN_HZ(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .power_on      (power_on),
      .run_state     (run_state),
      .finish        (finish),
      .model_choose  (model_choose),
      .current_time  (current_time),
      .total_time    (total_time),
      .current_water (current_water),
      .tick_1hz      (tick_1hz),
      .scan_tick     (scan_tick),
      .current_model (current_model),
      .digit_show    (digit_show),
      .AN            (AN)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clean button press: high for one cycle, then settle
   task automatic press();
      @(negedge clk) model_choose = 1'b1;
      @(negedge clk) model_choose = 1'b0;
      @(posedge clk); #1;
   endtask

   // Wait (bounded) for a scan_tick, then sample the digit it loads
   task automatic scan_expect(input string tag, input logic [7:0] an_exp, input logic [7:0] seg_exp);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (scan_tick) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      @(posedge clk); #1;
      check({tag, "_an"}, 32'(AN), 32'(an_exp));
      check({tag, "_seg"}, 32'(digit_show), 32'(seg_exp));
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
   endtask

   initial begin
      int tick_cnt, scan_cnt, first_tick, second_tick, first_scan, wide;
      logic prev_tick, prev_scan;
      logic [2:0] exp_seq [0:6];

      checks = 0;
      errors = 0;
      reset = 1'b1;
      power_on = 1'b0;
      run_state = 2'b00;
      finish = 1'b0;
      model_choose = 1'b0;
      current_time = 7'd0;
      total_time = 7'd0;
      current_water = 3'd0;

      // Reset values
      #22;
      check("rst_tick", 32'(tick_1hz), 32'd0);
      check("rst_scan", 32'(scan_tick), 32'd0);
      check("rst_model", 32'(current_model), 32'd7);
      check("rst_seg", 32'(digit_show), 32'hFF);
      check("rst_an", 32'(AN), 32'hFF);

      // Divider timing: count cycles after release
      @(negedge clk) reset = 1'b0;
      tick_cnt = 0; scan_cnt = 0; first_tick = 0; second_tick = 0;
      first_scan = 0; wide = 0; prev_tick = 1'b0; prev_scan = 1'b0;
      for (int n = 1; n <= 210; n++) begin
         @(posedge clk); #1;
         if (tick_1hz) begin
            tick_cnt++;
            if (tick_cnt == 1) first_tick = n;
            if (tick_cnt == 2) second_tick = n;
            if (prev_tick) wide++;
         end
         if (scan_tick) begin
            scan_cnt++;
            if (scan_cnt == 1) first_scan = n;
            if (prev_scan) wide++;
         end
         prev_tick = tick_1hz;
         prev_scan = scan_tick;
      end
      check("tick_first", 32'(first_tick), 32'd100);
      check("tick_second", 32'(second_tick), 32'd200);
      check("tick_count", 32'(tick_cnt), 32'd2);
      check("scan_first", 32'(first_scan), 32'd10);
      check("scan_count", 32'(scan_cnt), 32'd21);
      check("pulse_width", 32'(wide), 32'd0);

      // Mode cycling with 7 presses
      exp_seq[0] = 3'b100; exp_seq[1] = 3'b110; exp_seq[2] = 3'b010;
      exp_seq[3] = 3'b011; exp_seq[4] = 3'b001; exp_seq[5] = 3'b111;
      exp_seq[6] = 3'b100;
      @(negedge clk) power_on = 1'b1;
      for (int k = 0; k < 7; k++) begin
         press();
         check($sformatf("mode_press%0d", k + 1), 32'(current_model), 32'(exp_seq[k]));
      end

      // Held button gives one advance
      @(negedge clk) model_choose = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mode_held", 32'(current_model), 32'(3'b110));
      @(negedge clk) model_choose = 1'b0;

      // Running blocks advance
      @(negedge clk) run_state = 2'b01;
      press();
      check("mode_running", 32'(current_model), 32'(3'b110));
      // Paused allows advance
      @(negedge clk) run_state = 2'b10;
      press();
      check("mode_paused", 32'(current_model), 32'(3'b010));
      // Finish blocks advance
      @(negedge clk) begin run_state = 2'b00; finish = 1'b1; end
      press();
      check("mode_finish", 32'(current_model), 32'(3'b010));
      @(negedge clk) finish = 1'b0;
      // Power off forces full cycle and ignores presses
      @(negedge clk) power_on = 1'b0;
      @(posedge clk); #1;
      check("mode_poweroff", 32'(current_model), 32'd7);
      press();
      check("mode_off_press", 32'(current_model), 32'd7);

      // Display scan after a fresh reset
      current_time = 7'd45;
      total_time = 7'd120;
      current_water = 3'd3;
      power_on = 1'b1;
      do_reset();
      scan_expect("r1_d0", 8'hFE, 8'h92);
      scan_expect("r1_d1", 8'hFD, 8'h99);
      scan_expect("r1_d2", 8'hFB, 8'h90);
      scan_expect("r1_d3", 8'hF7, 8'h90);
      scan_expect("r1_d4", 8'hEF, 8'hB0);
      // Stable between ticks
      repeat (3) @(posedge clk);
      #1;
      check("hold_an", 32'(AN), 32'hEF);
      // New inputs appear on next visit of each digit
      @(negedge clk) begin current_time = 7'd7; current_water = 3'd0; total_time = 7'd99; end
      scan_expect("r2_d0", 8'hFE, 8'hF8);
      scan_expect("r2_d1", 8'hFD, 8'hC0);
      scan_expect("r2_d2", 8'hFB, 8'h90);
      scan_expect("r2_d3", 8'hF7, 8'h90);
      scan_expect("r2_d4", 8'hEF, 8'hC0);
      @(negedge clk) total_time = 7'd8;
      scan_expect("r3_d0", 8'hFE, 8'hF8);
      scan_expect("r3_d1", 8'hFD, 8'hC0);
      scan_expect("r3_d2", 8'hFB, 8'h80);
      scan_expect("r3_d3", 8'hF7, 8'hC0);

      // Power off blanks after one cycle
      @(negedge clk) power_on = 1'b0;
      @(posedge clk); #1;
      check("off_an", 32'(AN), 32'hFF);
      check("off_seg", 32'(digit_show), 32'hFF);
      @(negedge clk) power_on = 1'b1;

      // Asynchronous reset mid-scan
      scan_expect("pre_rst", 8'hEF, 8'hC0);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("arst_an", 32'(AN), 32'hFF);
      check("arst_seg", 32'(digit_show), 32'hFF);
      check("arst_model", 32'(current_model), 32'd7);
      check("arst_scan", 32'(scan_tick), 32'd0);
      @(negedge clk) reset = 1'b0;
      scan_expect("post_rst", 8'hFE, 8'hF8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
